// File: rtl/tdc_tot_capture.sv
// Time-over-threshold capture for one discriminator input. Pulse widths are
// measured in CLK cycles and queued as 32-bit words in a small FWFT buffer.
module tdc_tot_capture #(
    parameter logic [3:0] DATA_IDENTIFIER = 4'b0100,
    parameter int         FIFO_DEPTH      = 4
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        EN,
    input  logic        TDC_IN,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [11:0] EVENT_CNT,
    output logic [7:0]  LOST_CNT
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, READY, MEAS} state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              sync1_q, tdc_s_q, tdc_d_q;
    state_t            state_q, state_d;
    logic [11:0]       tot_q, tot_d;
    logic              wr_en;
    logic [31:0]       wr_word;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_vld_q, head_vld_d;
    logic [11:0]       event_q, event_d;
    logic [7:0]        lost_q, lost_d;
    logic              pop, push, drop, full;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            sync1_q <= 1'b0;
            tdc_s_q <= 1'b0;
            tdc_d_q <= 1'b0;
        end else begin
            sync1_q <= TDC_IN;
            tdc_s_q <= sync1_q;
            tdc_d_q <= tdc_s_q;
        end
    end

    // In MEAS a low tdc_s always follows a high one, so tdc_d is 1 there.
    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        wr_en   = 1'b0;
        if (!EN) begin
            state_d = IDLE;
            tot_d   = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = ARM;
                ARM:   if (!tdc_s_q) state_d = READY;
                READY: begin
                    if (tdc_s_q && !tdc_d_q) begin
                        state_d = MEAS;
                        tot_d   = 12'd1;
                    end
                end
                MEAS: begin
                    if (tdc_s_q) begin
                        tot_d = sat_inc12(tot_q);
                    end else if (tdc_d_q) begin
                        wr_en   = 1'b1;
                        state_d = READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_word = {DATA_IDENTIFIER, event_q, (tot_q == 12'hFFF), 3'b000, tot_q};

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= IDLE;
            tot_q   <= '0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
        end
    end

    // The head becomes visible one edge after the write; a pop exposes the
    // next word immediately.
    always_comb begin
        pop        = FIFO_READ && head_vld_q;
        full       = (cnt_q == DEPTH_C);
        push       = wr_en && (!full || pop);
        drop       = wr_en && !push;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        head_vld_d = (cnt_q - CNT_W'(pop)) != '0;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
        event_d    = push ? event_q + 12'd1 : event_q;
        lost_d     = drop ? sat_inc8(lost_q) : lost_q;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            event_q    <= '0;
            lost_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            head_vld_q <= head_vld_d;
            event_q    <= event_d;
            lost_q     <= lost_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= wr_word;
    end

    assign FIFO_EMPTY = !head_vld_q;
    assign FIFO_DATA  = head_vld_q ? mem_q[rptr_q] : 32'h0;
    assign EVENT_CNT  = event_q;
    assign LOST_CNT   = lost_q;

endmodule

// File: tb/tb_tdc_tot_capture.sv
// Scenario bench for tdc_tot_capture: expected words are queued as pulses are
// driven and checked as they come out of the buffer.
module tb_tdc_tot_capture;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_B, EN, TDC_IN, FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [11:0] EVENT_CNT;
    logic [7:0]  LOST_CNT;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    int          mocc   = 0;
    int          ev_m   = 0;
    int          lost_m = 0;

    always #5 CLK = ~CLK;

    tdc_tot_capture #(.DATA_IDENTIFIER(4'b0100), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_B(RST_B), .EN(EN), .TDC_IN(TDC_IN), .FIFO_READ(FIFO_READ),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .EVENT_CNT(EVENT_CNT), .LOST_CNT(LOST_CNT)
    );

    function automatic logic [31:0] exp_word(input int ev, input int len);
        int t;
        logic [11:0] ev12, t12;
        t    = (len > 4095) ? 4095 : len;
        ev12 = 12'(ev);
        t12  = 12'(t);
        return {4'b0100, ev12, (t == 4095), 3'b000, t12};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic model_write(input int len);
        if (mocc < DEPTH) begin
            exp_q.push_back(exp_word(ev_m, len));
            ev_m = (ev_m + 1) % 4096;
            mocc++;
        end else if (lost_m < 255) begin
            lost_m++;
        end
    endtask

    task automatic do_reset();
        RST_B = 1'b0; EN = 1'b0; TDC_IN = 1'b0; FIFO_READ = 1'b0;
        tick(2);
        RST_B = 1'b1;
        tick(1);
        exp_q.delete(); mocc = 0; ev_m = 0; lost_m = 0;
    endtask

    task automatic enable();
        EN = 1'b1;
        tick(3);
    endtask

    // Optionally pops the head on the very edge the new word is written.
    task automatic pulse(input int len, input bit rd_on_write);
        logic [31:0] e;
        TDC_IN = 1'b1;
        tick(len);
        TDC_IN = 1'b0;
        tick(2);
        if (rd_on_write) begin
            n_cmp++;
            if (exp_q.size() == 0 || FIFO_EMPTY !== 1'b0) begin
                n_fail++;
                $display("FAIL pop_on_write_head: FIFO_EMPTY=%b required 0", FIFO_EMPTY);
            end else begin
                e = exp_q.pop_front();
                mocc--;
                if (FIFO_DATA !== e) begin
                    n_fail++;
                    $display("FAIL pop_on_write_head: got %h required %h", FIFO_DATA, e);
                end
                FIFO_READ = 1'b1;
            end
        end
        model_write(len);
        tick(1);
        FIFO_READ = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string tag);
        int guard;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            guard = 0;
            while (FIFO_EMPTY === 1'b1 && guard < 10) begin
                tick(1);
                guard++;
            end
            n_cmp++;
            if (FIFO_EMPTY !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_timeout: FIFO_EMPTY=%b required 0 (%0d words pending)", tag, FIFO_EMPTY, exp_q.size());
                exp_q.delete();
                mocc = 0;
            end else begin
                e = exp_q.pop_front();
                if (FIFO_DATA !== e) begin
                    n_fail++;
                    $display("FAIL %s_word: got %h required %h", tag, FIFO_DATA, e);
                end
                FIFO_READ = 1'b1;
                tick(1);
                FIFO_READ = 1'b0;
                mocc--;
            end
        end
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || FIFO_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_empty: FIFO_EMPTY=%b DATA=%h required 1/00000000", tag, FIFO_EMPTY, FIFO_DATA);
        end
    endtask

    task automatic test_reset();
        RST_B = 1'b0; EN = 1'b0; TDC_IN = 1'b0; FIFO_READ = 1'b0;
        tick(2);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || FIFO_DATA !== 32'h0 || EVENT_CNT !== 12'd0 || LOST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: empty=%b data=%h ev=%0d lost=%0d required 1/0/0/0",
                     FIFO_EMPTY, FIFO_DATA, EVENT_CNT, LOST_CNT);
        end
        RST_B = 1'b1;
        tick(3);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || EVENT_CNT !== 12'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: empty=%b ev=%0d required 1/0", FIFO_EMPTY, EVENT_CNT);
        end
    endtask

    task automatic test_basic();
        do_reset();
        enable();
        FIFO_READ = 1'b1;
        tick(2);
        FIFO_READ = 1'b0;
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || EVENT_CNT !== 12'd0) begin
            n_fail++;
            $display("FAIL read_while_empty: empty=%b ev=%0d required 1/0", FIFO_EMPTY, EVENT_CNT);
        end
        TDC_IN = 1'b1;
        tick(10);
        TDC_IN = 1'b0;
        exp_q.push_back(32'h4000000A); mocc = 1; ev_m = 1;
        tick(3);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency_early: FIFO_EMPTY=%b required 1", FIFO_EMPTY);
        end
        tick(1);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b0 || EVENT_CNT !== 12'd1) begin
            n_fail++;
            $display("FAIL basic_latency: empty=%b ev=%0d required 0/1", FIFO_EMPTY, EVENT_CNT);
        end
        drain("basic");
    endtask

    task automatic test_overflow();
        do_reset();
        enable();
        pulse(5000, 1'b0);
        n_cmp++;
        if (FIFO_DATA !== 32'h40008FFF) begin
            n_fail++;
            $display("FAIL overflow_word: got %h required 40008fff", FIFO_DATA);
        end
        drain("overflow");
    endtask

    task automatic test_armed_high();
        do_reset();
        TDC_IN = 1'b1;
        tick(3);
        EN = 1'b1;
        tick(6);
        TDC_IN = 1'b0;
        tick(6);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || EVENT_CNT !== 12'd0) begin
            n_fail++;
            $display("FAIL armed_high_ignored: empty=%b ev=%0d required 1/0", FIFO_EMPTY, EVENT_CNT);
        end
        pulse(3, 1'b0);
        pulse(3, 1'b0);
        n_cmp++;
        if (EVENT_CNT !== 12'd2) begin
            n_fail++;
            $display("FAIL armed_high_count: got %0d required 2", EVENT_CNT);
        end
        drain("armed_high");
    endtask

    task automatic test_full_drop();
        do_reset();
        enable();
        for (int i = 1; i <= 6; i++) pulse(i, 1'b0);
        n_cmp++;
        if (EVENT_CNT !== 12'd4 || LOST_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL full_drop_counts: ev=%0d lost=%0d required 4/2", EVENT_CNT, LOST_CNT);
        end
    endtask

    task automatic test_full_write_pop();
        pulse(7, 1'b1);
        n_cmp++;
        if (EVENT_CNT !== 12'd5 || LOST_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL full_write_pop_counts: ev=%0d lost=%0d required 5/2", EVENT_CNT, LOST_CNT);
        end
        drain("full_write_pop");
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable();
        TDC_IN = 1'b1; tick(2);
        TDC_IN = 1'b0; tick(1);
        TDC_IN = 1'b1; tick(2);
        TDC_IN = 1'b0;
        model_write(2);
        model_write(2);
        tick(5);
        n_cmp++;
        if (EVENT_CNT !== 12'd2) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d required 2", EVENT_CNT);
        end
        drain("back_to_back");
        pulse(3, 1'b0);
        pulse(5, 1'b1);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b0 || LOST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL single_swap: empty=%b lost=%0d required 0/0", FIFO_EMPTY, LOST_CNT);
        end
        drain("single_swap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable();
        pulse(2, 1'b0);
        TDC_IN = 1'b1;
        tick(10);
        RST_B = 1'b0;
        #1;
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || FIFO_DATA !== 32'h0 || EVENT_CNT !== 12'd0 || LOST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: empty=%b data=%h ev=%0d lost=%0d required 1/0/0/0",
                     FIFO_EMPTY, FIFO_DATA, EVENT_CNT, LOST_CNT);
        end
        exp_q.delete(); mocc = 0; ev_m = 0; lost_m = 0;
        tick(10);
        TDC_IN = 1'b0;
        tick(4);
        RST_B = 1'b1;
        tick(8);
        n_cmp++;
        if (FIFO_EMPTY !== 1'b1 || EVENT_CNT !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid_noword: empty=%b ev=%0d required 1/0", FIFO_EMPTY, EVENT_CNT);
        end
    endtask

    task automatic test_en_drop();
        pulse(2, 1'b0);
        TDC_IN = 1'b1;
        tick(5);
        EN = 1'b0;
        tick(5);
        TDC_IN = 1'b0;
        tick(6);
        n_cmp++;
        if (EVENT_CNT !== 12'd1 || LOST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL en_drop_counts: ev=%0d lost=%0d required 1/0", EVENT_CNT, LOST_CNT);
        end
        drain("en_drop");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_armed_high();
        test_full_drop();
        test_full_write_pop();
        test_back_to_back();
        test_reset_mid();
        test_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
